// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - Pipeline-side bundle for the hazard/stall sequencer
//
// Purpose: groups the latch status inputs and the load/flush/redirect controls of
//          pipeline_hazard_ctrl into one interface.
// Modports:
//   master : pipeline side; drives latch status, branch resolution, stall and trap requests
//   slave  : sequencer side; drives the load enables, bubble/flush, PC select, ack, state, counter
// Signals:
//   DE_V, DE_IR[31:0], EXE_V, EXE_IR[31:0]   DE / EXE latch contents
//   EXE_BR_V, EXE_BR_TAKEN                   branch/JALR resolution from EXE
//   V_MEM_STALL, TRAP_REQ, CNT_CLR           front-end freeze, trap request, counter clear
//   LD_PC, LD_DE, DE_BUBBLE, FLUSH_DE        load enables and squash controls
//   PC_SEL[1:0], TRAP_ACK, CTRL_STATE[1:0]   next-PC select, trap accept pulse, sequencer state
//   STALL_CNT[CNT_W-1:0]                     saturating stall-cycle count
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             DE_V;
    logic [31:0]      DE_IR;
    logic             EXE_V;
    logic [31:0]      EXE_IR;
    logic             EXE_BR_V;
    logic             EXE_BR_TAKEN;
    logic             V_MEM_STALL;
    logic             TRAP_REQ;
    logic             CNT_CLR;
    logic             LD_PC;
    logic             LD_DE;
    logic             DE_BUBBLE;
    logic             FLUSH_DE;
    logic [1:0]       PC_SEL;
    logic             TRAP_ACK;
    logic [1:0]       CTRL_STATE;
    logic [CNT_W-1:0] STALL_CNT;

    modport master (
        output DE_V, DE_IR, EXE_V, EXE_IR, EXE_BR_V, EXE_BR_TAKEN,
               V_MEM_STALL, TRAP_REQ, CNT_CLR,
        input  LD_PC, LD_DE, DE_BUBBLE, FLUSH_DE, PC_SEL, TRAP_ACK,
               CTRL_STATE, STALL_CNT
    );

    modport slave (
        input  DE_V, DE_IR, EXE_V, EXE_IR, EXE_BR_V, EXE_BR_TAKEN,
               V_MEM_STALL, TRAP_REQ, CNT_CLR,
        output LD_PC, LD_DE, DE_BUBBLE, FLUSH_DE, PC_SEL, TRAP_ACK,
               CTRL_STATE, STALL_CNT
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - Stall/flush sequencer for the fetch/decode/execute front end
//
// Purpose: detects load-use hazards, holds fetch while EXE resolves branches/JALR, drains
//          the pipe on traps and counts stall cycles (saturating).
// Parameters:
//   TRAP_DRAIN : drain cycles after the trap-accept cycle (>=1)
//   CNT_W      : width of STALL_CNT (must match the interface CNT_W)
// Ports:
//   CLK        : clock, all state updates on posedge
//   RESET_N    : asynchronous active-low reset
//   bus        : pipeline_hazard_ctrl_if.slave, latch status in, pipeline controls out
module pipeline_hazard_ctrl #(
    parameter int TRAP_DRAIN = 2,
    parameter int CNT_W      = 32
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    pipeline_hazard_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_RUN        = 2'b00,
        S_BR_WAIT    = 2'b01,
        S_TRAP_DRAIN = 2'b10
    } state_t;

    localparam int DW = (TRAP_DRAIN < 2) ? 1 : $clog2(TRAP_DRAIN + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(TRAP_DRAIN);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       ld_pc, ld_de, de_bubble, flush_de, trap_ack;
    logic [1:0] pc_sel;

    // ---------------------------------------------------------------- decode
    logic [6:0] de_op, exe_op;
    logic [4:0] de_rs1, de_rs2, exe_rd;
    logic       br_de, uses_rs1, uses_rs2, ld_use;
    logic       unused_ir_bits;

    assign de_op  = bus.DE_IR[6:0];
    assign de_rs1 = bus.DE_IR[19:15];
    assign de_rs2 = bus.DE_IR[24:20];
    assign exe_op = bus.EXE_IR[6:0];
    assign exe_rd = bus.EXE_IR[11:7];

    assign unused_ir_bits = &{1'b0, bus.DE_IR[31:25], bus.DE_IR[14:7], bus.EXE_IR[31:12]};

    assign br_de    = bus.DE_V && ((de_op == OP_BRANCH) || (de_op == OP_JALR));
    assign uses_rs1 = !((de_op == OP_LUI) || (de_op == OP_AUIPC) || (de_op == OP_JAL));
    assign uses_rs2 = (de_op == OP_OP) || (de_op == OP_OP32) ||
                      (de_op == OP_STORE) || (de_op == OP_BRANCH);

    // A load in EXE whose destination feeds the DE instruction; x0 never creates a dependency.
    assign ld_use = bus.DE_V && bus.EXE_V && (exe_op == OP_LOAD) && (exe_rd != 5'd0) &&
                    (((exe_rd == de_rs1) && uses_rs1) || ((exe_rd == de_rs2) && uses_rs2));

    // ------------------------------------------------------ control outputs
    always_comb begin
        ld_pc     = 1'b0;
        ld_de     = 1'b0;
        de_bubble = 1'b0;
        flush_de  = 1'b0;
        pc_sel    = 2'b00;
        trap_ack  = 1'b0;
        state_d   = state_q;
        drain_d   = drain_q;

        if (!RESET_N) begin
            // Outputs must reach safe values while reset is held, without waiting for a clock.
            flush_de = 1'b1;
            state_d  = S_RUN;
            drain_d  = '0;
        end else if (bus.V_MEM_STALL) begin
            // Whole front end frozen: everything idle, state and drain count hold.
        end else if (bus.TRAP_REQ) begin
            ld_pc     = 1'b1;
            pc_sel    = 2'b10;
            flush_de  = 1'b1;
            de_bubble = 1'b1;
            trap_ack  = 1'b1;
            state_d   = S_TRAP_DRAIN;
            drain_d   = DRAIN_INIT;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (ld_use) begin
                        // One bubble is enough: the load leaves EXE and the match disappears.
                        de_bubble = 1'b1;
                    end else if (br_de) begin
                        // Move the branch into EXE and empty DE until it resolves.
                        ld_de    = 1'b1;
                        flush_de = 1'b1;
                        state_d  = S_BR_WAIT;
                    end else begin
                        ld_pc = 1'b1;
                        ld_de = 1'b1;
                    end
                end
                S_BR_WAIT: begin
                    flush_de = 1'b1;
                    if (bus.EXE_BR_V) begin
                        ld_pc   = 1'b1;
                        pc_sel  = bus.EXE_BR_TAKEN ? 2'b01 : 2'b00;
                        state_d = S_RUN;
                    end
                end
                S_TRAP_DRAIN: begin
                    flush_de  = 1'b1;
                    de_bubble = 1'b1;
                    drain_d   = drain_q - DW'(1);
                    if (drain_q <= DW'(1)) begin
                        drain_d = '0;
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_RUN;
                    drain_d = '0;
                end
            endcase
        end
    end

    // --------------------------------------------------------- stall counter
    logic stall_inc;

    assign stall_inc = !ld_de || de_bubble || (state_q != S_RUN);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.CNT_CLR) begin
            cnt_d = '0;
        end else if (stall_inc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // --------------------------------------------------------------- state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_RUN;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.LD_PC      = ld_pc;
    assign bus.LD_DE      = ld_de;
    assign bus.DE_BUBBLE  = de_bubble;
    assign bus.FLUSH_DE   = flush_de;
    assign bus.PC_SEL     = pc_sel;
    assign bus.TRAP_ACK   = trap_ack;
    assign bus.CTRL_STATE = state_q;
    assign bus.STALL_CNT  = cnt_q;

endmodule
